render_sweep_arbiter: RTL and testbench

- Shares one pixel-sweep engine and the framebuffer write port among NREQ rendering requesters, such as the screen clear, the element painter and the cursor overlay.
- Arbitrates round-robin, latches the winner's pixel count and walks a linear pixel index 0..limit-1. It stalls on write-port back-pressure and signals completion per requester.
- Sits between the render-stage controllers and the framebuffer writer.

---
 rtl/render_sweep_arbiter_if.sv | 24 ++
 rtl/render_sweep_arbiter.sv | 119 +++++++++++
 tb/tb_render_sweep_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/render_sweep_arbiter_if.sv
// Handshake bundle between render-stage controllers and the shared pixel-sweep arbiter.
interface render_sweep_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 17
);
  logic [NREQ-1:0]       req;
  logic [NREQ*IDX_W-1:0] limit_in;
  logic                  stall;
  logic [NREQ-1:0]       grant;
  logic [IDX_W-1:0]      pixel_idx;
  logic                  pixel_valid;
  logic [NREQ-1:0]       done;
  logic                  busy;

  modport master (
    output req, limit_in, stall,
    input  grant, pixel_idx, pixel_valid, done, busy
  );

  modport slave (
    input  req, limit_in, stall,
    output grant, pixel_idx, pixel_valid, done, busy
  );
endinterface

// File: rtl/render_sweep_arbiter.sv
// Round-robin arbiter sharing one linear pixel-sweep engine among NREQ requesters;
// the winner's pixel count is latched and walked 0..limit-1 with stall back-pressure.
module render_sweep_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 17
) (
  input  logic                 clk,
  input  logic                 resetn,
  render_sweep_arbiter_if.slave bus
);

  localparam int          OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned N  = NREQ;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [OW-1:0]     rr, rr_n, owner, owner_n, win, cw;
  logic [IDX_W-1:0]  lim, lim_n, idx, idx_n;
  logic [NREQ-1:0]   grant, grant_n, done, done_n;
  logic              valid, valid_n, busy, busy_n, found;
  int unsigned       c;
  logic [IDX_W-1:0]  lims [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_lim
    assign lims[g] = bus.limit_in[g*IDX_W +: IDX_W];
  end

  // First requesting bit at or above the rr pointer, wrapping around.
  always_comb begin
    win   = rr;
    found = 1'b0;
    c     = 0;
    cw    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      c = int'(rr) + k;
      if (c >= N) c = c - N;
      cw = OW'(c);
      if (!found && bus.req[cw]) begin
        found = 1'b1;
        win   = cw;
      end
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr;
    owner_n = owner;
    lim_n   = lim;
    idx_n   = idx;
    grant_n = grant;
    valid_n = valid;
    busy_n  = busy;
    done_n  = '0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (found) begin
          state_n = RUN;
          owner_n = win;
          lim_n   = lims[win];
          grant_n = NREQ'(1) << win;
          idx_n   = '0;
          valid_n = (lims[win] != '0);
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        // A zero-count sweep spends its single grant cycle here with pixel_valid low.
        if (lim == '0 || (!bus.stall && idx == lim - IDX_W'(1))) begin
          state_n = DONE;
          grant_n = '0;
          valid_n = 1'b0;
          done_n  = grant;
        end else if (!bus.stall) begin
          idx_n = idx + IDX_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        rr_n    = (owner == OW'(NREQ-1)) ? '0 : owner + OW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      rr    <= '0;
      owner <= '0;
      lim   <= '0;
      idx   <= '0;
      grant <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= '0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
      owner <= owner_n;
      lim   <= lim_n;
      idx   <= idx_n;
      grant <= grant_n;
      valid <= valid_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  assign bus.grant       = grant;
  assign bus.pixel_idx   = idx;
  assign bus.pixel_valid = valid;
  assign bus.done        = done;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_render_sweep_arbiter.sv
// Directed bench for render_sweep_arbiter: single sweep, round-robin, stall,
// zero count, full frame and asynchronous reset mid-sweep.
module tb_render_sweep_arbiter;
  localparam int NREQ  = 4;
  localparam int IDX_W = 17;

  logic clk = 1'b0;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  render_sweep_arbiter_if #(.NREQ(NREQ), .IDX_W(IDX_W)) bus ();

  render_sweep_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lim(input int i, input int v);
    bus.limit_in[i*IDX_W +: IDX_W] = IDX_W'(v);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.req = '0;
    bus.stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  int exp_idx [7] = '{0, 1, 1, 1, 2, 3, 3};
  int stl     [7] = '{0, 1, 1, 0, 0, 1, 0};
  int cnt, bad, last, own;

  initial begin
    bus.limit_in = '0;
    do_reset();
    check("rst_grant", 64'(bus.grant), 0);
    check("rst_idx",   64'(bus.pixel_idx), 0);
    check("rst_valid", 64'(bus.pixel_valid), 0);
    check("rst_done",  64'(bus.done), 0);
    check("rst_busy",  64'(bus.busy), 0);

    // Single sweep, requester 1, five pixels
    @(negedge clk);
    bus.req = 4'b0010;
    set_lim(1, 5);
    @(negedge clk);
    check("s1_grant", 64'(bus.grant), 64'b0010);
    check("s1_busy",  64'(bus.busy), 1);
    check("s1_idx0",  64'(bus.pixel_idx), 0);
    check("s1_val0",  64'(bus.pixel_valid), 1);
    bus.req = '0;
    for (int p = 1; p < 5; p++) begin
      @(negedge clk);
      check("s1_idx", 64'(bus.pixel_idx), 64'(p));
      check("s1_val", 64'(bus.pixel_valid), 1);
    end
    @(negedge clk);
    check("s1_done",   64'(bus.done), 64'b0010);
    check("s1_dgrant", 64'(bus.grant), 0);
    check("s1_dval",   64'(bus.pixel_valid), 0);
    check("s1_dbusy",  64'(bus.busy), 1);
    @(negedge clk);
    check("s1_done_off", 64'(bus.done), 0);
    check("s1_idle_busy", 64'(bus.busy), 0);
    check("s1_idx_hold", 64'(bus.pixel_idx), 4);

    // Round-robin with all four requesting, limit 2 each
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lim(i, 2);
    bus.req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      own = s % NREQ;
      @(negedge clk);
      check("rr_grant", 64'(bus.grant), 64'(1) << own);
      check("rr_idx0",  64'(bus.pixel_idx), 0);
      @(negedge clk);
      check("rr_idx1",  64'(bus.pixel_idx), 1);
      check("rr_val1",  64'(bus.pixel_valid), 1);
      @(negedge clk);
      check("rr_done",  64'(bus.done), 64'(1) << own);
      check("rr_gap1",  64'(bus.pixel_valid), 0);
      if (s == 4) bus.req = '0;
      @(negedge clk);
      check("rr_gap2",  64'(bus.pixel_valid), 0);
      check("rr_idle_grant", 64'(bus.grant), 0);
    end
    @(negedge clk);
    check("rr_end_grant", 64'(bus.grant), 0);

    // Stall: limit 4 on requester 0
    do_reset();
    set_lim(0, 4);
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = '0;
    for (int i = 0; i < 7; i++) begin
      check("st_idx", 64'(bus.pixel_idx), 64'(exp_idx[i]));
      check("st_val", 64'(bus.pixel_valid), 1);
      bus.stall = stl[i][0];
      @(negedge clk);
    end
    check("st_done", 64'(bus.done), 64'b0001);
    check("st_dval", 64'(bus.pixel_valid), 0);

    // Zero-count sweep on requester 2
    @(negedge clk);
    bus.req = 4'b0100;
    set_lim(2, 0);
    @(negedge clk);
    check("z_grant", 64'(bus.grant), 64'b0100);
    check("z_val",   64'(bus.pixel_valid), 0);
    check("z_nodone", 64'(bus.done), 0);
    check("z_idx",   64'(bus.pixel_idx), 0);
    bus.req = '0;
    @(negedge clk);
    check("z_done",  64'(bus.done), 64'b0100);
    check("z_val2",  64'(bus.pixel_valid), 0);
    check("z_dgrant", 64'(bus.grant), 0);
    @(negedge clk);
    check("z_busy", 64'(bus.busy), 0);

    // Full frame, 320x240 pixels
    do_reset();
    set_lim(0, 76800);
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = '0;
    check("ff_grant", 64'(bus.grant), 64'b0001);
    cnt = 0; bad = 0; last = -1;
    for (int c = 0; c < 80000 && bus.pixel_valid; c++) begin
      if (int'(bus.pixel_idx) != cnt) bad++;
      last = int'(bus.pixel_idx);
      cnt++;
      @(negedge clk);
    end
    check("ff_count", 64'(cnt), 76800);
    check("ff_last",  64'(last), 76799);
    check("ff_seq_errors", 64'(bad), 0);
    check("ff_done",  64'(bus.done), 64'b0001);

    // Reset mid-sweep on requester 1 (rr pointer is 1 here)
    @(negedge clk);
    bus.req = 4'b0010;
    set_lim(1, 100);
    @(negedge clk);
    check("rm_grant", 64'(bus.grant), 64'b0010);
    bus.req = '0;
    for (int c = 0; c < 60 && bus.pixel_idx != IDX_W'(37); c++) @(negedge clk);
    check("rm_at37", 64'(bus.pixel_idx), 37);
    resetn = 1'b0;
    #1;
    check("rm_grant0", 64'(bus.grant), 0);
    check("rm_idx0",   64'(bus.pixel_idx), 0);
    check("rm_val0",   64'(bus.pixel_valid), 0);
    check("rm_done0",  64'(bus.done), 0);
    check("rm_busy0",  64'(bus.busy), 0);
    @(negedge clk);
    check("rm_nodone", 64'(bus.done), 0);
    bus.req = 4'b1000;
    set_lim(3, 3);
    resetn = 1'b1;
    @(negedge clk);
    check("rm_regrant", 64'(bus.grant), 64'b1000);
    check("rm_reidx",   64'(bus.pixel_idx), 0);
    bus.req = '0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
